// File: rtl/svo_pkg.sv
// Shared video scan-out constants: timing defaults, tuser bits, register map.
// Also holds the pixel bundle type and a small window-compare helper.
package svo_pkg;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int H_FP_DEF     = 110;
  localparam int H_SYNC_DEF   = 40;
  localparam int H_BP_DEF     = 220;
  localparam int V_ACTIVE_DEF = 720;
  localparam int V_FP_DEF     = 5;
  localparam int V_SYNC_DEF   = 5;
  localparam int V_BP_DEF     = 20;

  localparam int TU_SOF   = 0;
  localparam int TU_HSYNC = 1;
  localparam int TU_VSYNC = 2;
  localparam int TU_BLANK = 3;

  localparam logic [3:0] REG_BASE = 4'h0;

  localparam int FIFO_DEPTH = 16;

  typedef struct packed {
    logic [23:0] data;
    logic [3:0]  user;
  } pix_t;

  // true when lo <= c < lo+n
  function automatic logic in_win(
    input logic [15:0] c,
    input int          lo,
    input int          n
  );
    return (c >= 16'(lo)) && (c < 16'(lo + n));
  endfunction

endpackage

// File: rtl/svo_fifo.sv
// First-word-fall-through FIFO buffering prefetched framebuffer words.
// Flush empties it in one cycle; writes when full are ignored.
module svo_fifo #(
  parameter int W  = 32,
  parameter int D  = 16,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_wr_en,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_rd_en,
  output logic [W-1:0]  o_rdata,
  output logic [AW:0]   o_count,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign w_wr    = i_wr_en && (r_cnt != (AW+1)'(D));
  assign w_rd    = i_rd_en && (r_cnt != '0);
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end

endmodule

// File: rtl/system_top.sv
// Framebuffer scan-out: raster timing, prefetching reader, 3-byte unpacker.
// Base/enable latch at each frame boundary; active pixels stall on memory.
module system_top
  import svo_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_wr_en,
  input  logic [3:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        out_axis_tvalid,
  input  logic        out_axis_tready,
  output logic [23:0] out_axis_tdata,
  output logic [3:0]  out_axis_tuser,
  output logic        led_0
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [31:0] WORDS = 32'(H_ACTIVE * V_ACTIVE * 3 / 4);
  localparam int FAW = $clog2(FIFO_DEPTH);

  logic [31:0] r_base;
  logic [31:0] r_addr;
  logic [31:0] r_wleft;
  logic        r_cur_en;
  logic [15:0] r_h;
  logic [15:0] r_v;
  pix_t        r_out;
  logic        r_vld;
  logic        r_led;
  logic [7:0]  r_pend;
  logic [7:0]  r_drop;
  logic [55:0] r_sh;
  logic [2:0]  r_nb;

  logic          w_act;
  logic          w_last;
  logic          w_avail;
  logic          w_adv;
  logic          w_load;
  logic          w_flush;
  logic          w_cons;
  logic          w_en_new;
  pix_t          w_pix;
  logic          w_fire;
  logic [7:0]    w_pend_nxt;
  logic [7:0]    w_live;
  logic          w_room;
  logic          w_fifo_wr;
  logic          w_pop;
  logic [31:0]   w_fdata;
  logic [FAW:0]  w_fcnt;
  logic          w_fempty;
  logic [2:0]    w_nb_aft;
  logic [55:0]   w_sh_aft;

  assign w_act  = (r_h < 16'(H_ACTIVE)) && (r_v < 16'(V_ACTIVE));
  assign w_last = (r_h == 16'(H_TOT - 1)) && (r_v == 16'(V_TOT - 1));
  assign w_avail  = !w_act || !r_cur_en || (r_nb >= 3'd3);
  assign w_adv    = !r_vld || out_axis_tready;
  assign w_load   = w_adv && w_avail;
  assign w_flush  = w_load && w_last;
  assign w_cons   = w_load && w_act && r_cur_en;
  assign w_en_new = (r_base != '0);

  assign w_live     = r_pend - r_drop;
  assign w_room     = (8'(w_fcnt) + w_live) < 8'(FIFO_DEPTH);
  assign w_fire     = mem_req_valid && mem_req_ready;
  assign w_pend_nxt = r_pend + 8'(w_fire) - 8'(mem_rsp_valid);
  assign w_fifo_wr  = mem_rsp_valid && (r_drop == '0) && !w_flush;

  assign mem_req_valid = r_cur_en && (r_wleft != '0) && w_room &&
                         (r_pend != 8'hFF) && !w_flush;
  assign mem_req_addr  = r_addr;

  assign out_axis_tvalid = r_vld;
  assign out_axis_tdata  = r_out.data;
  assign out_axis_tuser  = r_out.user;
  assign led_0           = r_led;

  svo_fifo #(
    .W (32),
    .D (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_wr_en (w_fifo_wr),
    .i_wdata (mem_rsp_data),
    .i_rd_en (w_pop),
    .o_rdata (w_fdata),
    .o_count (w_fcnt),
    .o_empty (w_fempty)
  );

  // pixel at the current raster position
  always_comb begin
    w_pix = '0;
    w_pix.user[TU_SOF]   = (r_h == '0) && (r_v == '0);
    w_pix.user[TU_HSYNC] = in_win(r_h, H_ACTIVE + H_FP, H_SYNC);
    w_pix.user[TU_VSYNC] = in_win(r_v, V_ACTIVE + V_FP, V_SYNC);
    w_pix.user[TU_BLANK] = !w_act;
    if (w_act && r_cur_en) w_pix.data = r_sh[23:0];
  end

  // framebuffer base register; low two bits never stored
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base <= '0;
    end else if (reg_wr_en && (reg_addr == REG_BASE)) begin
      r_base <= reg_wdata & ~32'h3;
    end
  end

  // raster position advances each time a pixel enters the output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_load) begin
      if (r_h == 16'(H_TOT - 1)) begin
        r_h <= '0;
        r_v <= (r_v == 16'(V_TOT - 1)) ? '0 : r_v + 16'd1;
      end else begin
        r_h <= r_h + 16'd1;
      end
    end
  end

  // output stage: holds pixel until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= 1'b0;
      r_out <= '0;
    end else if (w_adv) begin
      r_vld <= w_avail;
      if (w_avail) r_out <= w_pix;
    end
  end

  // heartbeat toggles on each accepted start-of-frame pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led <= 1'b0;
    end else if (r_vld && out_axis_tready && r_out.user[TU_SOF]) begin
      r_led <= ~r_led;
    end
  end

  // read address, remaining words and frame-latched enable
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_en <= 1'b0;
      r_addr   <= '0;
      r_wleft  <= '0;
    end else if (w_flush) begin
      r_cur_en <= w_en_new;
      r_addr   <= r_base;
      r_wleft  <= w_en_new ? WORDS : '0;
    end else if (w_fire) begin
      r_addr  <= r_addr + 32'd4;
      r_wleft <= r_wleft - 32'd1;
    end
  end

  // outstanding responses; those from before a flush are discarded
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_drop <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_flush) begin
        r_drop <= w_pend_nxt;
      end else if (mem_rsp_valid && (r_drop != '0)) begin
        r_drop <= r_drop - 8'd1;
      end
    end
  end

  // unpacker: bytes left after consuming a pixel, refill when room for a word
  always_comb begin
    w_nb_aft = r_nb;
    w_sh_aft = r_sh;
    if (w_cons) begin
      w_nb_aft = r_nb - 3'd3;
      w_sh_aft = r_sh >> 24;
    end
    w_pop = !w_fempty && (w_nb_aft <= 3'd3) && !w_flush;
  end

  // unpacker byte buffer
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_sh <= '0;
      r_nb <= '0;
    end else if (w_pop) begin
      r_sh <= w_sh_aft | ({24'd0, w_fdata} << {w_nb_aft, 3'b000});
      r_nb <= w_nb_aft + 3'd4;
    end else begin
      r_sh <= w_sh_aft;
      r_nb <= w_nb_aft;
    end
  end

endmodule

// File: tb/tb_system_top.sv
// Scoreboard bench for system_top on a shrunk 14x7 raster (8x4 active).
// Directed frames: disabled, base A, base B mid-frame, disable, reset.
module tb_system_top;

  localparam int HA  = 8;
  localparam int HF  = 2;
  localparam int HS  = 2;
  localparam int HB  = 2;
  localparam int VA  = 4;
  localparam int VF  = 1;
  localparam int VS  = 1;
  localparam int VB  = 1;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int WPF = HA * VA * 3 / 4;
  localparam int LIMIT = 20000;
  localparam logic [31:0] BASE_A = 32'h0008_0000;
  localparam logic [31:0] BASE_B = 32'h0010_0000;

  typedef struct packed {
    logic [23:0] d;
    logic [3:0]  u;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_wr_en = 1'b0;
  logic [3:0]  reg_addr = 4'h0;
  logic [31:0] reg_wdata = 32'h0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic        out_axis_tvalid;
  logic        out_axis_tready = 1'b0;
  logic [23:0] out_axis_tdata;
  logic [3:0]  out_axis_tuser;
  logic        led_0;

  int total = 0;
  int bad = 0;
  int nsof = 0;
  int nreq = 0;
  int rq_cnt = 0;
  logic exp_led = 1'b0;
  logic rnd = 1'b0;
  logic [31:0] cur_base = 32'h0;

  exp_t        sb_q[$];
  mreq_t       mq[$];
  logic [31:0] exp_bases[$];

  logic [23:0] pat_a [4] = '{24'h112233, 24'h223300, 24'h330011, 24'h001122};
  logic [23:0] pat_b [4] = '{24'hAABBCC, 24'hBBCC00, 24'hCC00AA, 24'h00AABB};

  always #5 clk = ~clk;

  system_top #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .reg_wr_en       (reg_wr_en),
    .reg_addr        (reg_addr),
    .reg_wdata       (reg_wdata),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .out_axis_tvalid (out_axis_tvalid),
    .out_axis_tready (out_axis_tready),
    .out_axis_tdata  (out_axis_tdata),
    .out_axis_tuser  (out_axis_tuser),
    .led_0           (led_0)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // mode 0: scan-out disabled, 1: base A pattern, 2: base B pattern
  task automatic push_frame(input int mode);
    int   k;
    exp_t e;
    k = 0;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        e.u[0] = (h == 0) && (v == 0);
        e.u[1] = (h >= HA + HF) && (h < HA + HF + HS);
        e.u[2] = (v >= VA + VF) && (v < VA + VF + VS);
        e.u[3] = (h >= HA) || (v >= VA);
        e.d = 24'h0;
        if (!e.u[3]) begin
          if (mode == 1) e.d = pat_a[k % 4];
          else if (mode == 2) e.d = pat_b[k % 4];
          k++;
        end
        sb_q.push_back(e);
      end
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >= BASE_B) ? 32'h00AABBCC : 32'h00112233;
  endfunction

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_wr_en = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge clk);
    reg_wr_en = 1'b0;
  endtask

  task automatic wait_sof(input int n);
    int t;
    t = 0;
    while (nsof < n && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIMIT) chk("sof_timeout", 32'(nsof), 32'(n));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIMIT) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  // memory model and tready driver: inputs change at negedge, handshakes
  // sampled just after, ahead of the posedge that acts on them
  initial begin : mem_model
    logic [31:0] cyc;
    logic [31:0] last_due;
    logic [31:0] due;
    mreq_t       r;
    cyc = 0;
    last_due = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        mq.delete();
        mem_rsp_valid   = 1'b0;
        mem_req_ready   = 1'b0;
        out_axis_tready = 1'b1;
      end else begin
        if (mq.size() != 0 && mq[0].due <= cyc) begin
          r = mq.pop_front();
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_word(r.a);
        end else begin
          mem_rsp_valid = 1'b0;
          mem_rsp_data  = 32'h0;
        end
        mem_req_ready   = rnd ? ($urandom_range(0, 9) < 6) : 1'b1;
        out_axis_tready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
        #1;
        if (mem_req_valid && mem_req_ready) begin
          if (rq_cnt == 0) begin
            if (exp_bases.size() != 0) cur_base = exp_bases.pop_front();
            else cur_base = 32'hFFFF_FFFF;
          end
          chk("req_addr", mem_req_addr, cur_base + 32'(4 * rq_cnt));
          rq_cnt = (rq_cnt == WPF - 1) ? 0 : rq_cnt + 1;
          nreq++;
          due = cyc + (rnd ? 32'($urandom_range(1, 6)) : 32'd2);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          r.a = mem_req_addr;
          r.due = due;
          mq.push_back(r);
        end
      end
    end
  end

  // monitor: pops the scoreboard on every accepted pixel
  initial begin : monitor
    exp_t        e;
    logic        pv;
    logic [23:0] pd;
    logic [3:0]  pu;
    pv = 1'b0;
    pd = '0;
    pu = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          chk("hold_valid", 32'(out_axis_tvalid), 32'd1);
          chk("hold_data", 32'(out_axis_tdata), 32'(pd));
          chk("hold_user", 32'(out_axis_tuser), 32'(pu));
        end
        if (out_axis_tvalid && out_axis_tready) begin
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("pix_data", 32'(out_axis_tdata), 32'(e.d));
            chk("pix_user", 32'(out_axis_tuser), 32'(e.u));
          end
          if (out_axis_tuser[0]) begin
            chk("led", 32'(led_0), 32'(exp_led));
            exp_led = ~exp_led;
            nsof++;
          end
        end
        pv = out_axis_tvalid && !out_axis_tready;
        pd = out_axis_tdata;
        pu = out_axis_tuser;
      end
    end
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tvalid", 32'(out_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(out_axis_tdata), 32'd0);
    chk("rst_tuser", 32'(out_axis_tuser), 32'd0);
    chk("rst_led", 32'(led_0), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);

    push_frame(0);
    push_frame(0);
    push_frame(1);
    push_frame(1);
    push_frame(2);
    push_frame(0);
    exp_bases.push_back(BASE_A);
    exp_bases.push_back(BASE_A);
    exp_bases.push_back(BASE_B);

    @(negedge clk);
    reset = 1'b0;

    wait_sof(2);
    write_reg(4'h0, BASE_A);
    wait_sof(3);
    rnd = 1'b1;
    wait_sof(4);
    write_reg(4'h0, BASE_B | 32'h3);
    wait_sof(5);
    write_reg(4'h0, 32'h0);
    wait_drain();

    chk("req_total", 32'(nreq), 32'(3 * WPF));
    chk("req_bases_left", 32'(exp_bases.size()), 32'd0);
    chk("req_partial", 32'(rq_cnt), 32'd0);

    repeat (40) @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    #1;
    chk("mid_rst_tvalid", 32'(out_axis_tvalid), 32'd0);
    chk("mid_rst_tdata", 32'(out_axis_tdata), 32'd0);
    chk("mid_rst_tuser", 32'(out_axis_tuser), 32'd0);
    chk("mid_rst_led", 32'(led_0), 32'd0);
    chk("mid_rst_req", 32'(mem_req_valid), 32'd0);
    exp_led = 1'b0;
    push_frame(0);
    @(negedge clk);
    reset = 1'b0;
    wait_drain();
    chk("post_rst_reqs", 32'(nreq), 32'(3 * WPF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/system_top.md
SYSTEM_TOP -- requirements
Module: system_top

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 110/40/220, horizontal blanking in pixels.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 5/5/20, vertical blanking in lines.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1: sole clock, rising edge.
REQ-007 Port reset, input, 1: synchronous active-high reset.
REQ-008 Port reg_wr_en, input, 1: register write strobe, one write per asserted cycle.
REQ-009 Port reg_addr, input, 4: register byte offset.
REQ-010 Port reg_wdata, input, 32: register write data.
REQ-011 Port mem_req_valid, output, 1: memory read request valid.
REQ-012 Port mem_req_ready, input, 1: memory accepts request.
REQ-013 Port mem_req_addr, output, 32: byte address, word aligned.
REQ-014 Port mem_rsp_valid, input, 1: read data valid; responses return in request order.
REQ-015 Port mem_rsp_data, input, 32: read word, little-endian.
REQ-016 Port out_axis_tvalid, output, 1: pixel valid.
REQ-017 Port out_axis_tready, input, 1: downstream accepts pixel.
REQ-018 Port out_axis_tdata, output, 24: pixel; [7:0], [15:8], [23:16] are bytes 0, 1, 2 of the pixel.
REQ-019 Port out_axis_tuser, output, 4: [0] start of frame, [1] hsync, [2] vsync, [3] blank.
REQ-020 Port led_0, output, 1: frame heartbeat.

Function
REQ-021 Offset 0x0 SHALL be the framebuffer base register; write bits[1:0] are ignored; a nonzero value enables scan-out, zero disables it.
REQ-022 Each frame SHALL be (H_ACTIVE+H_FP+H_SYNC+H_BP) x (V_ACTIVE+V_FP+V_SYNC+V_BP) transfers, 1650x750 by default, raster order with active region first.
REQ-023 Timing counters SHALL advance only on a transfer (tvalid && tready); tdata/tuser SHALL hold while tvalid && !tready.
REQ-024 tuser[0] SHALL be 1 only on pixel (0,0); hsync SHALL be high for H_SYNC pixels after H_ACTIVE+H_FP; vsync SHALL be high for V_SYNC lines after V_ACTIVE+V_FP; blank SHALL be 1 outside the active region.
REQ-025 Blank pixels SHALL carry tdata 0 and be valid unconditionally.
REQ-026 The framebuffer SHALL be packed 3 bytes per pixel, contiguous; pixel n = bytes 3n..3n+2 from base; 3 words yield 4 pixels.
REQ-027 Active pixels while enabled SHALL come from memory; while an active pixel's bytes are unavailable, tvalid SHALL be 0 (stall, never drop or substitute).
REQ-028 Active pixels while disabled SHALL be 0x000000 and never stall.
REQ-029 Reader SHALL prefetch into a 16-word FIFO, issuing a request only when the FIFO has room for all outstanding responses; the address SHALL increment by 4 per request.
REQ-030 Base/enable changes SHALL take effect at the next frame start; at frame start the read address SHALL reload to base and the FIFO/unpacker SHALL be flushed, discarding in-flight responses.
REQ-031 Reads SHALL stop after H_ACTIVE*V_ACTIVE*3/4 words per frame (691200 default).
REQ-032 led_0 SHALL toggle on each SOF transfer.

Reset
REQ-033 Reset SHALL clear base to 0, disable scan-out, zero counters, flush FIFO, and drive mem_req_valid=0, out_axis_tvalid=0, tdata=0, tuser=0, led_0=0.
REQ-034 The first valid pixel after reset release SHALL be (0,0) with tuser=4'b0001.

Structure
REQ-035 Timing defaults, tuser bit indices and the register offset SHALL be in shared package svo_pkg.
REQ-036 The 16x32 FIFO SHALL be sub-module svo_fifo; timing, reader and unpacker SHALL be in system_top.

Verification
REQ-037 Reset, tready=1, disabled: SOF every 1237500 transfers; active tdata 0; led_0 toggles per frame.
REQ-038 Fill memory at 0x00080000 with 0x00112233, write base 0x00080000: the next frame's first pixels are 0x112233, 0x223300, 0x330011, 0x001122, repeating.
REQ-039 Random tready and random memory latency: pixel sequence identical to REQ-038; no tdata/tuser change while stalled.
REQ-040 Count per frame: exactly 691200 memory requests, 1280 hsync-low active pixels per active line, 5 vsync lines.
REQ-041 Write base mid-frame: the current frame is unchanged and the new base is used from the next SOF.
REQ-042 Reset asserted mid-frame: outputs clear next cycle; after release the stream restarts at SOF.
